neuron_mac_engine: RTL and testbench

Sequencer and multiply-accumulate datapath that sits directly upstream of the weight ROM. It drives the ROM's 8-bit address and enable, and consumes the 8-bit weight returned combinationally. Each weight is multiplied with a streamed input activation, and the signed dot product for one neuron is returned over a valid/ready result interface. One engine instance computes one neuron at a time; the layer controller issues start per neuron with that neuron's base address.

---
 rtl/nn_pkg.sv | 14 +
 rtl/mac_pipe.sv | 46 ++++
 rtl/neuron_mac_engine.sv | 116 +++++++++++
 tb/tb_neuron_mac_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared widths and FSM state encoding for the neuron MAC engine.
package nn_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/mac_pipe.sv
// Two-stage multiply/accumulate pipeline: registered product, then accumulate.
module mac_pipe
    import nn_pkg::*;
#(
    parameter int DATA_W = nn_pkg::DATA_W,
    parameter int ACC_W  = nn_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] act,
    output logic                     prod_valid,
    output logic signed [ACC_W-1:0]  acc_sum
);
    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod_reg;
    logic                    prod_valid_reg;
    logic signed [ACC_W-1:0] acc_reg;

    // Accumulator value including any product still sitting in the multiply stage.
    assign acc_sum    = prod_valid_reg ? acc_reg + ACC_W'(prod_reg) : acc_reg;
    assign prod_valid = prod_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg       <= '0;
            prod_valid_reg <= 1'b0;
            acc_reg        <= '0;
        end else if (clear) begin
            prod_reg       <= '0;
            prod_valid_reg <= 1'b0;
            acc_reg        <= '0;
        end else begin
            prod_valid_reg <= load;
            if (load) begin
                prod_reg <= PW'(weight) * PW'(act);
            end
            if (prod_valid_reg) begin
                acc_reg <= acc_sum;
            end
        end
    end
endmodule

// File: rtl/neuron_mac_engine.sv
// Per-neuron sequencer: walks the weight ROM, pairs weights with streamed
// activations and returns the signed dot product over a valid/ready port.
module neuron_mac_engine
    import nn_pkg::*;
#(
    parameter int ADDR_W = nn_pkg::ADDR_W,
    parameter int DATA_W = nn_pkg::DATA_W,
    parameter int ACC_W  = nn_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_inputs,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);
    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [7:0]        n_reg;
    logic [7:0]        idx_reg;
    logic [ACC_W-1:0]  result_reg;
    logic              accept;
    logic              clear;
    logic              prod_valid;
    logic signed [ACC_W-1:0] acc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        clear      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = (num_inputs == 8'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (idx_reg == 8'(n_reg - 8'd1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: state_next = DONE;
            DONE: begin
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg   <= '0;
            n_reg      <= '0;
            idx_reg    <= '0;
            result_reg <= '0;
        end else begin
            if (clear) begin
                base_reg   <= base_addr;
                n_reg      <= num_inputs;
                idx_reg    <= '0;
                result_reg <= '0;
            end
            if (accept) begin
                idx_reg <= idx_reg + 8'd1;
            end
            // The final product is still in the multiply stage here, so take the bypassed sum.
            if (state_reg == DRAIN) begin
                result_reg <= acc_sum;
            end
        end
    end

    mac_pipe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load       (accept),
        .weight     (rom_data),
        .act        (in_data),
        .prod_valid (prod_valid),
        .acc_sum    (acc_sum)
    );

    assign rom_en       = (state_reg == FETCH);
    assign in_ready     = (state_reg == FETCH);
    assign rom_addr     = rom_en ? ADDR_W'(base_reg + ADDR_W'(idx_reg)) : '0;
    assign result       = result_reg;
    assign result_valid = (state_reg == DONE);
    assign busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_neuron_mac_engine.sv
// Randomized self-checking bench for neuron_mac_engine against a dot-product model.
module tb_neuron_mac_engine;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  num_inputs;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data;
    logic [23:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    logic [7:0] rom [256];
    logic [7:0] act_q [$];
    int n_checks;
    int n_fails;

    neuron_mac_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_inputs   (num_inputs),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rom_addr     (rom_addr),
        .rom_en       (rom_en),
        .rom_data     (rom_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    assign rom_data = rom_en ? rom[rom_addr] : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // mode: 0 = in_valid always high, 1 = toggled 1,0,1,0, 2 = random
    task automatic run_neuron(input logic [7:0] b, input int n, input int mode,
                              input int hold, input bit use_req, input int req);
        logic [7:0] acts [$];
        logic [7:0] a;
        logic [7:0] exp_addr;
        int exp_sum, k, e, en_cnt, phase, held_result;
        exp_sum = 0;
        for (int i = 0; i < n; i++) begin
            if (act_q.size() > 0) a = act_q.pop_front();
            else a = 8'($urandom);
            acts.push_back(a);
            exp_addr = 8'(b + 8'(i));
            exp_sum += int'($signed(rom[exp_addr])) * int'($signed(a));
        end
        if (use_req) exp_sum = req;

        @(negedge clk);
        start = 1'b1; base_addr = b; num_inputs = 8'(n);
        @(negedge clk);
        start = 1'b0; base_addr = 8'($urandom); num_inputs = 8'($urandom);
        check_val("busy_after_start", int'(busy), 1);
        e = 0; k = 0; en_cnt = 0; phase = 0;
        while (!result_valid && e < 600) begin
            if (rom_en) en_cnt++;
            in_valid = 1'b0;
            if (in_ready && k < n) begin
                exp_addr = 8'(b + 8'(k));
                check_val("rom_addr", int'(rom_addr), int'(exp_addr));
                check_val("rom_en", int'(rom_en), 1);
                if (mode == 0 || (mode == 1 && phase == 0) ||
                    (mode == 2 && $urandom_range(0, 1) == 1)) begin
                    in_valid = 1'b1;
                    in_data  = acts[k];
                    k++;
                end
                phase ^= 1;
            end
            @(negedge clk);
            e++;
        end
        in_valid = 1'b0;
        check_val("result_valid_timeout", int'(result_valid), 1);
        if (mode == 0) check_val("latency", e, (n == 0) ? 0 : n + 1);
        if (n == 0) check_val("rom_en_cycles", en_cnt, 0);
        check_val("accepted", k, n);
        check_val("result", int'($signed(result)), exp_sum);
        check_val("rom_en_done", int'(rom_en), 0);
        check_val("in_ready_done", int'(in_ready), 0);
        held_result = int'($signed(result));
        for (int i = 0; i < hold; i++) begin
            start = (i == 1);
            base_addr = 8'($urandom); num_inputs = 8'($urandom_range(1, 9));
            @(negedge clk);
            check_val("hold_valid", int'(result_valid), 1);
            check_val("hold_result", int'($signed(result)), held_result);
            check_val("hold_busy", int'(busy), 1);
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check_val("valid_cleared", int'(result_valid), 0);
        check_val("idle_busy", int'(busy), 0);
        $display("neuron base=%02h n=%0d mode=%0d latency=%0d result=%0d expected=%0d",
                 b, n, mode, e, $signed(result), exp_sum);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_result"}, int'(result), 0);
        check_val({tag, "_valid"}, int'(result_valid), 0);
        check_val({tag, "_in_ready"}, int'(in_ready), 0);
        check_val({tag, "_rom_en"}, int'(rom_en), 0);
        check_val({tag, "_rom_addr"}, int'(rom_addr), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic abort_test();
        @(negedge clk);
        start = 1'b1; base_addr = 8'h20; num_inputs = 8'd8;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
        @(negedge clk);
        in_data = 8'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("abort_rom_addr", int'(rom_addr), 8'h22);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        $display("abort at idx=2 base=20 n=8, async reset observed");
    endtask

    initial begin
        n_checks = 0; n_fails = 0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_inputs = '0;
        in_data = '0; in_valid = 1'b0; result_ready = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'd1; rom[1] = 8'd3; rom[2] = 8'd5; rom[3] = 8'd7;
        rom[8'h10] = 8'hFF; rom[8'h11] = 8'h80;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        repeat (4) act_q.push_back(8'd1);
        run_neuron(8'h00, 4, 0, 0, 1'b1, 16);
        act_q.push_back(8'h80); act_q.push_back(8'h80);
        run_neuron(8'h10, 2, 0, 0, 1'b1, 16512);
        run_neuron(8'hFE, 4, 1, 0, 1'b0, 0);
        run_neuron(8'h40, 0, 0, 0, 1'b1, 0);
        run_neuron(8'h33, 3, 0, 5, 1'b0, 0);
        abort_test();
        run_neuron(8'h20, 8, 0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 255; j++) act_q.push_back(8'h80);
            rom[8'(8'h80 + 8'(i))] = 8'h80;
        end
        for (int i = 0; i < 255; i++) rom[i] = 8'h80;
        run_neuron(8'h00, 255, 0, 0, 1'b1, 255 * 16384);
        act_q.delete();
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        for (int t = 0; t < 12; t++) begin
            run_neuron(8'($urandom), $urandom_range(0, 20), $urandom_range(0, 2),
                       $urandom_range(0, 3), 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
